// File: rtl/jump_ctrl_ras.sv
// Next-PC select with a circular return-address stack and a post-redirect flush counter.
// Define RAS_CHECK_EN to build the return-address comparator that drives ras_miss.
module jump_ctrl_ras #(
    parameter int AW           = 32,
    parameter int DEPTH        = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       Zero,
    input  logic                       Branch,
    input  logic                       BranchNe,
    input  logic                       Jr,
    input  logic                       JrRa,
    input  logic                       Jump,
    input  logic                       Link,
    input  logic [AW-1:0]              pc_plus4,
    input  logic [AW-1:0]              jr_target,
    output logic [1:0]                 JumpOP,
    output logic [AW-1:0]              ras_top,
    output logic                       ras_valid,
    output logic [$clog2(DEPTH+1)-1:0] ras_count,
    output logic                       ras_overflow,
    output logic                       ras_underflow,
    output logic                       flush,
    output logic                       ras_miss
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

    logic [AW-1:0] mem_q [DEPTH];
    logic [AW-1:0] mem_d [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          miss_q, miss_d;
    logic          push, pop, redirect, miss_now;

    always_comb begin
        if ((Branch && Zero) || (BranchNe && !Zero)) JumpOP = 2'b01;
        else if (Jr)                                 JumpOP = 2'b10;
        else if (Jump)                               JumpOP = 2'b11;
        else                                         JumpOP = 2'b00;
    end

    assign push     = Link;
    assign pop      = Jr && JrRa;
    assign redirect = (JumpOP != 2'b00);

`ifdef RAS_CHECK_EN
    // An empty-stack pop has no prediction, so it is always a miss.
    assign miss_now = pop && ((cnt_q == '0) || (ras_top != jr_target));
`else
    logic unused_jr_target;
    assign unused_jr_target = ^jr_target;
    assign miss_now = 1'b0;
`endif

    always_comb begin
        mem_d  = mem_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        miss_d = miss_q;
        fcnt_d = fcnt_q;
        if (!stall) begin
            unf_d  = 1'b0;
            miss_d = miss_now;
            if (push && pop && (cnt_q != '0)) begin
                mem_d[ptr_q] = pc_plus4;
            end else if (push) begin
                // When full, ptr+1 is the oldest entry, so wrapping overwrites it.
                mem_d[ptr_q + PW'(1)] = pc_plus4;
                ptr_d = ptr_q + PW'(1);
                if (cnt_q == CW'(DEPTH)) ovf_d = 1'b1;
                else                     cnt_d = cnt_q + CW'(1);
            end else if (pop) begin
                if (cnt_q != '0) begin
                    ptr_d = ptr_q - PW'(1);
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    unf_d = 1'b1;
                end
            end
            if (redirect)            fcnt_d = FW'(FLUSH_CYCLES);
            else if (fcnt_q != '0)   fcnt_d = fcnt_q - FW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            miss_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            miss_q <= miss_d;
            fcnt_q <= fcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign ras_top       = (cnt_q == '0) ? '0 : mem_q[ptr_q];
    assign ras_valid     = (cnt_q != '0);
    assign ras_count     = cnt_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;
    assign flush         = (fcnt_q != '0);
    assign ras_miss      = miss_q;
endmodule
